ov7670_config_seq: RTL and testbench



---
 rtl/ov7670_pkg.sv | 29 ++
 rtl/ov7670_config_seq_if.sv | 32 +++
 rtl/ov7670_config_seq.sv | 179 +++++++++++++++++
 tb/tb_ov7670_config_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared types and constants for the OV7670 configuration sequencer.
//   state_e        - sequencer FSM states
//   CMD_END        - register-table end marker
//   CMD_DELAY      - register-table delay command
//   OV7670_SCCB_ID - camera SCCB write address
package ov7670_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StHwrst,
        StPwrup,
        StFetch,
        StDecode,
        StSend,
        StDelay,
        StSettle,
        StDone,
        StError
    } state_e;

    localparam logic [15:0] CMD_END        = 16'hFFFF;
    localparam logic [15:0] CMD_DELAY      = 16'hFFF0;
    localparam logic [7:0]  OV7670_SCCB_ID = 8'h42;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ov7670_config_seq_if.sv
// ov7670_config_seq_if: request/acknowledge link between the configuration
// sequencer (master) and the SCCB byte sender (slave).
//   sccb_send  - master holds high while an entry is offered
//   sccb_taken - one-cycle acknowledge from the sender
//   sccb_id    - device address (constant)
//   sccb_reg   - register address, stable while sccb_send is high
//   sccb_val   - register value, stable while sccb_send is high
interface ov7670_config_seq_if;

    logic       sccb_send;
    logic       sccb_taken;
    logic [7:0] sccb_id;
    logic [7:0] sccb_reg;
    logic [7:0] sccb_val;

    modport master (
        output sccb_send,
        output sccb_id,
        output sccb_reg,
        output sccb_val,
        input  sccb_taken
    );

    modport slave (
        input  sccb_send,
        input  sccb_id,
        input  sccb_reg,
        input  sccb_val,
        output sccb_taken
    );

endinterface

// File: rtl/ov7670_config_seq.sv
// ov7670_config_seq: powers up the OV7670, walks the register-table ROM and
// feeds each write to the SCCB sender, then enables pixel capture.
// Ports:
//   clk, rst_n      - system clock, synchronous active-low reset
//   start           - one-cycle pulse, (re)runs the sequence from IDLE/DONE/ERROR
//   tbl_addr        - ROM address; tbl_data is valid one cycle later
//   tbl_data        - ROM word {reg, val}, or CMD_END / CMD_DELAY
//   sccb            - master side of the SCCB sender handshake
//   cam_reset_n     - camera hardware reset pin
//   cam_pwdn        - camera power-down pin (high only in IDLE)
//   busy            - sequence in progress (HWRST through SETTLE)
//   config_done     - sequence finished successfully
//   error           - sender never acknowledged an entry
//   capture_en      - gates the pixel-capture write path
module ov7670_config_seq
    import ov7670_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned RST_LOW_CYC = CLK_HZ / 1000,
    parameter int unsigned PWRUP_CYC   = CLK_HZ / 1000,
    parameter int unsigned DELAY_CYC   = CLK_HZ / 100,
    parameter int unsigned SETTLE_CYC  = CLK_HZ / 5,
    parameter int unsigned TIMEOUT_CYC = CLK_HZ / 100,
    parameter int unsigned AW          = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] tbl_addr,
    input  logic [15:0]   tbl_data,
    ov7670_config_seq_if.master sccb,
    output logic          cam_reset_n,
    output logic          cam_pwdn,
    output logic          busy,
    output logic          config_done,
    output logic          error,
    output logic          capture_en
);

    localparam int unsigned CntMax = max2(max2(max2(RST_LOW_CYC, PWRUP_CYC),
                                               max2(DELAY_CYC, SETTLE_CYC)), TIMEOUT_CYC);
    localparam int unsigned CW = (CntMax > 1) ? $clog2(CntMax) : 1;

    // Loaded with N-1 on entry so a timed state lasts exactly N cycles.
    localparam logic [CW-1:0] RstLd     = CW'(RST_LOW_CYC - 1);
    localparam logic [CW-1:0] PwrupLd   = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0] DelayLd   = CW'(DELAY_CYC - 1);
    localparam logic [CW-1:0] SettleLd  = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] TimeoutLd = CW'(TIMEOUT_CYC - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    reg_q, reg_d;
    logic [7:0]    val_q, val_d;
    logic          send_q, rst_n_pin_q, pwdn_q, busy_q, done_q, error_q, capture_q;
    logic          cnt_zero, last_entry;

    assign cnt_zero   = (cnt_q == '0);
    assign last_entry = (addr_q == '1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        reg_d   = reg_q;
        val_d   = val_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d = StHwrst;
                    cnt_d   = RstLd;
                end
            end
            StHwrst: begin
                if (cnt_zero) begin
                    state_d = StPwrup;
                    cnt_d   = PwrupLd;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StPwrup: begin
                if (cnt_zero) begin
                    state_d = StFetch;
                    addr_d  = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                if (tbl_data == CMD_END) begin
                    state_d = StSettle;
                    cnt_d   = SettleLd;
                end else if (tbl_data == CMD_DELAY) begin
                    state_d = StDelay;
                    cnt_d   = DelayLd;
                end else begin
                    state_d = StSend;
                    cnt_d   = TimeoutLd;
                    reg_d   = tbl_data[15:8];
                    val_d   = tbl_data[7:0];
                end
            end
            StSend, StDelay: begin
                // Acknowledge wins over a timeout landing on the same cycle.
                if ((state_q == StSend && sccb.sccb_taken && send_q) ||
                    (state_q == StDelay && cnt_zero)) begin
                    addr_d = addr_q + AW'(1);
                    // Running off the top of the table counts as its end.
                    if (last_entry) begin
                        state_d = StSettle;
                        cnt_d   = SettleLd;
                    end else begin
                        state_d = StFetch;
                    end
                end else if (cnt_zero) begin
                    state_d = StError;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StSettle: begin
                if (cnt_zero) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            reg_q       <= '0;
            val_q       <= '0;
            send_q      <= 1'b0;
            rst_n_pin_q <= 1'b1;
            pwdn_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            capture_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            reg_q       <= reg_d;
            val_q       <= val_d;
            send_q      <= (state_d == StSend);
            rst_n_pin_q <= (state_d != StHwrst);
            pwdn_q      <= (state_d == StIdle);
            busy_q      <= (state_d inside {StHwrst, StPwrup, StFetch, StDecode,
                                            StSend, StDelay, StSettle});
            done_q      <= (state_d == StDone);
            error_q     <= (state_d == StError);
            capture_q   <= (state_d == StDone);
        end
    end

    assign tbl_addr       = addr_q;
    assign sccb.sccb_send = send_q;
    assign sccb.sccb_id   = OV7670_SCCB_ID;
    assign sccb.sccb_reg  = reg_q;
    assign sccb.sccb_val  = val_q;
    assign cam_reset_n    = rst_n_pin_q;
    assign cam_pwdn       = pwdn_q;
    assign busy           = busy_q;
    assign config_done    = done_q;
    assign error          = error_q;
    assign capture_en     = capture_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// tb_ov7670_config_seq: drives the configuration sequencer against a small
// synchronous ROM and an SCCB sender model with configurable acknowledge delay.
module tb_ov7670_config_seq;

    localparam int unsigned RST_LOW = 4;
    localparam int unsigned PWRUP   = 4;
    localparam int unsigned DLY     = 8;
    localparam int unsigned SETTLE  = 10;
    localparam int unsigned TMO     = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic        cam_reset_n, cam_pwdn, busy, config_done, error, capture_en;

    ov7670_config_seq_if sccb_bus ();

    ov7670_config_seq #(
        .RST_LOW_CYC (RST_LOW),
        .PWRUP_CYC   (PWRUP),
        .DELAY_CYC   (DLY),
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TMO),
        .AW          (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .tbl_addr    (tbl_addr),
        .tbl_data    (tbl_data),
        .sccb        (sccb_bus.master),
        .cam_reset_n (cam_reset_n),
        .cam_pwdn    (cam_pwdn),
        .busy        (busy),
        .config_done (config_done),
        .error       (error),
        .capture_en  (capture_en)
    );

    initial forever #5 clk = ~clk;

    // Synchronous register-table ROM.
    logic [15:0] rom [256];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard and event log shared with the sender/monitor process.
    logic [15:0] exp_q[$];
    int          send_rises[$];
    int          takens[$];
    int          cyc = 0;
    int          xfer_cnt = 0;
    int          rst_low_cnt = 0;
    int          cap_rise = -1;
    int          err_rise = -1;
    bit          ack_en = 1'b0;
    int          ack_dly = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Sender model and event monitor, evaluated on the falling edge.
    initial begin
        int  wait_cnt;
        bit  prev_send, prev_cap, prev_err;
        wait_cnt  = 0;
        prev_send = 1'b0;
        prev_cap  = 1'b0;
        prev_err  = 1'b0;
        sccb_bus.sccb_taken = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            sccb_bus.sccb_taken = 1'b0;
            if (sccb_bus.sccb_send && !prev_send) send_rises.push_back(cyc);
            if (capture_en && !prev_cap) cap_rise = cyc;
            if (error && !prev_err) err_rise = cyc;
            if (!cam_reset_n) rst_low_cnt++;
            if (ack_en && sccb_bus.sccb_send) begin
                wait_cnt++;
                if (wait_cnt >= ack_dly) begin
                    sccb_bus.sccb_taken = 1'b1;
                    wait_cnt = 0;
                    takens.push_back(cyc);
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_unexpected: got %02h%02h want none",
                                 sccb_bus.sccb_reg, sccb_bus.sccb_val);
                    end else begin
                        check("sb_xfer", {sccb_bus.sccb_id, sccb_bus.sccb_reg, sccb_bus.sccb_val},
                              {8'h42, exp_q.pop_front()});
                    end
                end
            end else begin
                wait_cnt = 0;
            end
            prev_send = sccb_bus.sccb_send;
            prev_cap  = capture_en;
            prev_err  = error;
        end
    end

    task automatic clear_log();
        exp_q.delete();
        send_rises.delete();
        takens.delete();
        xfer_cnt    = 0;
        rst_low_cnt = 0;
        cap_rise    = -1;
        err_rise    = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Four table words, word 0 in the top bits; the rest of the ROM is CMD_END.
    task automatic load_rom(input logic [63:0] w, input bit push);
        logic [15:0] e;
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        for (int i = 0; i < 4; i++) rom[i] = w[63-16*i -: 16];
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                e = w[63-16*i -: 16];
                if (e == 16'hFFFF) break;
                if (e != 16'hFFF0) exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_end(input string name, input int budget);
        int n;
        n = 0;
        while (!(config_done || error) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_reached_end"}, 32'(config_done | error), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pins"}, {cam_pwdn, cam_reset_n}, 2'b11);
        check({tag, "_addr"}, tbl_addr, 8'h00);
        check({tag, "_sccb"}, {sccb_bus.sccb_send, sccb_bus.sccb_id, sccb_bus.sccb_reg,
                               sccb_bus.sccb_val}, {1'b0, 8'h42, 8'h00, 8'h00});
        check({tag, "_flags"}, {busy, config_done, error, capture_en}, 4'b0000);
    endtask

    typedef struct {
        string       name;
        logic [63:0] words;
        bit          ack;
        int          exp_xfers;
        bit          exp_done;
        bit          exp_err;
        logic [7:0]  exp_addr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;

        vecs[0] = '{"two_writes",  64'h1280_1101_FFFF_FFFF, 1'b1, 2, 1'b1, 1'b0, 8'd2};
        vecs[1] = '{"with_delay",  64'h1280_FFF0_1101_FFFF, 1'b1, 2, 1'b1, 1'b0, 8'd3};
        vecs[2] = '{"empty_table", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 1'b1, 1'b0, 8'd0};
        vecs[3] = '{"no_ack",      64'h1280_FFFF_FFFF_FFFF, 1'b0, 0, 1'b0, 1'b1, 8'd0};
        vecs[4] = '{"two_delays",  64'h3A04_FFF0_FFF0_FFFF, 1'b1, 1, 1'b1, 1'b0, 8'd3};

        do_reset();
        check_reset_outputs("reset");

        // Table-driven whole-sequence runs.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            ack_en  = vecs[v].ack;
            ack_dly = 3;
            load_rom(vecs[v].words, vecs[v].ack);
            pulse_start();
            wait_end(vecs[v].name, 400);
            @(negedge clk);
            check({vecs[v].name, "_xfers"}, xfer_cnt, vecs[v].exp_xfers);
            check({vecs[v].name, "_done_cap_err"}, {config_done, capture_en, error},
                  {vecs[v].exp_done, vecs[v].exp_done, vecs[v].exp_err});
            check({vecs[v].name, "_send_busy"}, {sccb_bus.sccb_send, busy}, 2'b00);
            check({vecs[v].name, "_addr"}, tbl_addr, vecs[v].exp_addr);
            check({vecs[v].name, "_sb_empty"}, exp_q.size(), 0);
        end

        // Basic timing: reset width, per-write overhead, settle latency.
        do_reset();
        ack_en  = 1'b1;
        ack_dly = 3;
        load_rom(64'h1280_1101_FFFF_FFFF, 1'b1);
        pulse_start();
        wait_end("basic", 400);
        check("basic_reset_low", rst_low_cnt, RST_LOW);
        check("basic_takens", takens.size(), 2);
        if (takens.size() == 2 && send_rises.size() == 2) begin
            // taken, FETCH, DECODE, then SEND: next send rises 3 cycles after taken.
            check("basic_write_gap", send_rises[1] - takens[0], 3);
            // taken, FETCH, DECODE(end), SETTLE x10, capture on the 11th cycle after decode.
            check("basic_capture_lat", cap_rise - takens[1], 2 + SETTLE + 1);
        end

        // Delay command between two writes: FETCH+DECODE of the delay word,
        // DELAY_CYC, then FETCH+DECODE+SEND of the next write.
        do_reset();
        load_rom(64'h1280_FFF0_1101_FFFF, 1'b1);
        pulse_start();
        wait_end("delay", 400);
        check("delay_rises", send_rises.size(), 2);
        if (takens.size() >= 1 && send_rises.size() >= 2)
            check("delay_gap", send_rises[1] - takens[0], 2 + DLY + 3);

        // Timeout: sender never answers.
        do_reset();
        ack_en = 1'b0;
        load_rom(64'h1280_FFFF_FFFF_FFFF, 1'b0);
        pulse_start();
        wait_end("timeout", 400);
        if (send_rises.size() == 1) check("timeout_len", err_rise - send_rises[0], TMO);
        check("timeout_flags", {error, capture_en, sccb_bus.sccb_send, busy}, 4'b1000);

        // Restart from ERROR.
        ack_en = 1'b1;
        load_rom(64'h1280_1101_FFFF_FFFF, 1'b1);
        rst_low_cnt = 0;
        xfer_cnt    = 0;
        pulse_start();
        check("restart_err_clear", {error, cam_reset_n, busy}, 3'b001);
        wait_end("restart", 400);
        check("restart_reset_low", rst_low_cnt, RST_LOW);
        check("restart_done", {config_done, capture_en, error}, 3'b110);
        check("restart_xfers", xfer_cnt, 2);

        // Start while busy is ignored; reset mid-SEND aborts everything.
        do_reset();
        ack_en = 1'b0;
        load_rom(64'h1280_FFFF_FFFF_FFFF, 1'b0);
        pulse_start();
        for (int n = 0; n < 100 && !sccb_bus.sccb_send; n++) @(negedge clk);
        check("midrst_in_send", sccb_bus.sccb_send, 1'b1);
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        check("busy_start_ignored", {cam_reset_n, sccb_bus.sccb_send, busy}, 3'b111);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;

        // No end marker: 256 writes, address wraps, then SETTLE and DONE.
        do_reset();
        ack_en  = 1'b1;
        ack_dly = 1;
        for (int i = 0; i < 256; i++) begin
            rom[i] = {8'h20, 8'(i)};
            exp_q.push_back({8'h20, 8'(i)});
        end
        pulse_start();
        wait_end("wrap", 3000);
        check("wrap_xfers", xfer_cnt, 256);
        check("wrap_done", {config_done, capture_en, error}, 3'b110);
        check("wrap_addr", tbl_addr, 8'h00);
        check("wrap_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
